regfile_dump: RTL and testbench
===============================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter M, default 5: register index width.
REQ-002 The block SHALL have parameter N, default 32: register data width (byte-multiple).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  dump request, sampled in IDLE only.
REQ-006 abort  input  1  synchronous cancel of a dump in progress.
REQ-007 first_reg  input  M  first register index of the dump, latched on accepted start.
REQ-008 last_reg  input  M  last register index of the dump, latched on accepted start.
REQ-009 rd_addr  output  M  drives the register bank read_reg port.
REQ-010 rd_data  input  N  combinational register bank read_data for rd_addr.
REQ-011 out_data  output  8  stream byte.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  sink accepts byte; transfer = out_valid & out_ready at rising edge.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the final byte of a dump transfers.

Function
REQ-016 Stream format SHALL be: header byte 0xA5, then per register one index byte {zero-padded index} followed by N/8 data bytes, MSB first.
REQ-017 FSM states SHALL be IDLE, HEADER, ADDR, CAPTURE, SEND, NEXT, FINISH.
REQ-018 IDLE -> HEADER on start=1; first_reg/last_reg latched, index counter loaded with first_reg.
REQ-019 HEADER: out_valid=1, out_data=0xA5; on transfer -> ADDR.
REQ-020 ADDR: rd_addr = index counter, out_valid=0; unconditionally -> CAPTURE next cycle.
REQ-021 CAPTURE: rd_data captured into an N-bit snapshot register at the end of this cycle, rd_addr still held; byte counter cleared; -> SEND.
REQ-022 SEND: byte 0 = index byte, bytes 1..N/8 = snapshot MSB first; byte counter advances only on transfer; after the last byte transfers -> NEXT.
REQ-023 NEXT: if index == latched last_reg -> FINISH, else index increments modulo 2^M and -> ADDR.
REQ-024 FINISH: done=1 for exactly this cycle, out_valid=0; -> IDLE.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL remain stable and out_valid SHALL stay high.
REQ-026 Minimum per-register cost with out_ready held high SHALL be 2 + (N/8+1) + 1 cycles (8 cycles at N=32).
REQ-027 first_reg > last_reg SHALL wrap through 2^M-1 to 0 and stop after last_reg; first_reg == last_reg SHALL dump exactly one register.
REQ-028 start while busy=1 SHALL be ignored; latched range SHALL not change mid-dump.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, drop out_valid immediately that edge, and produce no done pulse; abort overrides a simultaneous transfer.
REQ-030 start and abort both high in IDLE: abort wins, dump not started.
REQ-031 Snapshot value SHALL be the register content seen in CAPTURE; bank writes after CAPTURE SHALL not alter bytes already captured.
REQ-032 rd_addr SHALL hold the index counter value in every state (no glitching to other indices).

Reset
REQ-033 reset_n=0 SHALL, asynchronously, force IDLE with out_valid=0, out_data=0, busy=0, done=0, rd_addr=0, counters and snapshot=0.
REQ-034 Reset asserted mid-dump SHALL discard the dump; after release the block waits in IDLE for a new start.

Verification
REQ-035 Bank reg5=15, first=last=5, out_ready=1, start pulse -> bytes A5,05,00,00,00,0F; done pulses once; busy low after done.
REQ-036 first=30, last=1, out_ready=1 -> indices 1E,1F,00,01 in order, 21 bytes total, one done pulse.
REQ-037 Same as REQ-035 with out_ready toggling 1/0 every cycle -> identical byte sequence, out_data stable during every stalled cycle.
REQ-038 Abort asserted while the third data byte is pending -> out_valid low next edge, busy low, no done; subsequent start produces a complete correct frame.
REQ-039 reset_n pulled low in SEND -> outputs zero immediately without clock; start pulse during active dump -> ignored, range unchanged.
REQ-040 Bank write of 0xDEADBEEF to reg 5 in the cycle after CAPTURE -> streamed data bytes 00,00,00,0F.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: streams a 0xA5 header, then an index byte and N/8 data bytes (MSB first)
// for each register from first_reg up to last_reg, wrapping modulo 2^M.
module regfile_dump #(
  parameter int M = 5,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [M-1:0] first_reg,
  input  logic [M-1:0] last_reg,
  output logic [M-1:0] rd_addr,
  input  logic [N-1:0] rd_data,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);
  localparam int NB = N / 8;
  localparam int BW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, HEADER, ADDR, CAPTURE, SEND, NEXT, FINISH} state_t;
  state_t state, state_nx;
  logic [M-1:0] idx, last_q;
  logic [N-1:0] snap, snap_sh;
  logic [BW-1:0] bcnt;
  logic xfer, last_byte;
  assign xfer = out_valid & out_ready;
  assign last_byte = bcnt == BW'(NB);
  // byte k (k >= 1) of the snapshot is moved to the top so it can be sliced off
  assign snap_sh = snap << {bcnt - BW'(1), 3'b000};
  assign out_valid = state == HEADER || state == SEND;
  assign out_data = state == HEADER ? 8'hA5 :
                    state != SEND ? 8'h00 :
                    bcnt == '0 ? 8'(idx) : snap_sh[N-1 -: 8];
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign rd_addr = idx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? HEADER : IDLE;
      HEADER:  state_nx = xfer ? ADDR : HEADER;
      ADDR:    state_nx = CAPTURE;
      CAPTURE: state_nx = SEND;
      SEND:    state_nx = xfer && last_byte ? NEXT : SEND;
      NEXT:    state_nx = idx == last_q ? FINISH : ADDR;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      last_q <= '0;
      snap   <= '0;
      bcnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && !abort) begin
        idx    <= first_reg;
        last_q <= last_reg;
      end
      if (state == CAPTURE) begin
        snap <= rd_data;
        bcnt <= '0;
      end
      if (state == SEND && xfer && !abort) bcnt <= bcnt + BW'(1);
      if (state == NEXT && !abort && idx != last_q) idx <= idx + M'(1);
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed and randomized dumps checked against a byte-queue model of the stream.
module tb_regfile_dump;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, out_ready = 1;
  logic [4:0] first_reg = 0, last_reg = 0, rd_addr;
  logic [31:0] rd_data;
  logic [7:0] out_data;
  logic out_valid, busy, done;
  logic [31:0] bank [32];
  logic [7:0] got_q[$], exp_q[$];
  int done_cnt = 0, stall_bad = 0, tests = 0, fails = 0;
  logic stalled = 0;
  logic [7:0] stall_data = 0;

  always #5 clk = ~clk;
  assign rd_data = bank[rd_addr];

  regfile_dump #(.M(5), .N(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Inputs change just after the rising edge, so the falling edge sees what the next edge will act on.
  always @(negedge clk) begin
    if (stalled && reset_n && !(out_valid && out_data == stall_data)) stall_bad++;
    stalled = reset_n && out_valid && !out_ready && !abort;
    stall_data = out_data;
    if (reset_n && out_valid && out_ready && !abort) got_q.push_back(out_data);
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int f, input int l);
    int i;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    i = f;
    forever begin
      exp_q.push_back(8'(i));
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(bank[i] >> (8 * b)));
      if (i == l) break;
      i = (i + 1) % 32;
    end
  endtask

  task automatic compare_frame(input string tag, input int base);
    check({tag, "_len"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) check({tag, "_byte"}, 64'(got_q[base + i]), 64'(exp_q[i]));
  endtask

  task automatic run_dump(input string tag, input int f, input int l, input int mode,
                          input int poke_c, input int write_c, output int cyc);
    int base, d0, c;
    base = got_q.size();
    d0 = done_cnt;
    first_reg = 5'(f);
    last_reg = 5'(l);
    start = 1;
    step();
    start = 0;
    c = 1;
    while (busy && c < 400) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? c[0] : 1'($urandom_range(0, 1));
      if (c == poke_c) begin
        start = 1;
        first_reg = 5'd7;
        last_reg = 5'd7;
      end
      if (c == poke_c + 1) start = 0;
      if (c == write_c) bank[5] = 32'hDEADBEEF;
      step();
      c++;
    end
    out_ready = 1;
    start = 0;
    check({tag, "_timeout"}, 64'(c < 400), 64'd1);
    compare_frame(tag, base);
    check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    cyc = c;
  endtask

  initial begin
    int cyc, base, d0, c, f, l;
    for (int i = 0; i < 32; i++) bank[i] = $urandom;
    bank[5] = 32'd15;
    #1;
    check("rst_outputs", {out_valid, busy, done, rd_addr, out_data}, 64'd0);
    step();
    step();
    reset_n = 1;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    build_exp(5, 5);
    run_dump("single", 5, 5, 0, -1, -1, cyc);
    check("single_cycles", 64'(cyc), 64'(3 + 8 * 1));

    build_exp(30, 1);
    run_dump("wrap_poke", 30, 1, 0, 10, -1, cyc);
    check("wrap_cycles", 64'(cyc), 64'(3 + 8 * 4));

    build_exp(5, 5);
    run_dump("toggle", 5, 5, 1, -1, -1, cyc);
    check("stall_stable", 64'(stall_bad), 64'd0);

    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    check("start_abort_idle", 64'(busy), 64'd0);

    build_exp(5, 5);
    base = got_q.size();
    d0 = done_cnt;
    first_reg = 5;
    last_reg = 5;
    start = 1;
    step();
    start = 0;
    c = 0;
    while (got_q.size() - base < 4 && c < 50) begin
      step();
      c++;
    end
    check("abort_reach", 64'(c < 50), 64'd1);
    check("abort_pending", {out_valid, out_data}, {1'b1, exp_q[4]});
    abort = 1;
    step();
    abort = 0;
    check("abort_drop", {out_valid, busy}, 64'd0);
    step();
    step();
    check("abort_bytes", 64'(got_q.size() - base), 64'd4);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_dump("after_abort", 5, 5, 0, -1, -1, cyc);

    build_exp(3, 4);
    base = got_q.size();
    d0 = done_cnt;
    first_reg = 3;
    last_reg = 4;
    start = 1;
    step();
    start = 0;
    c = 0;
    while (got_q.size() - base < 2 && c < 50) begin
      step();
      c++;
    end
    #2;
    reset_n = 0;
    #1;
    check("rst_mid", {out_valid, busy, done, rd_addr, out_data}, 64'd0);
    step();
    reset_n = 1;
    step();
    step();
    step();
    check("rst_idle", 64'(busy), 64'd0);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);

    bank[5] = 32'd15;
    build_exp(5, 5);
    run_dump("late_write", 5, 5, 0, -1, 4, cyc);
    check("late_write_bank", 64'(bank[5]), 64'hDEADBEEF);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) bank[i] = $urandom;
      f = $urandom_range(0, 31);
      l = (f + $urandom_range(0, 3)) % 32;
      build_exp(f, l);
      run_dump("random", f, l, 2, -1, -1, cyc);
    end
    check("stall_stable_final", 64'(stall_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
